// File: rtl/ei_axi4_slave_responder_if.sv
// AXI4 bus bundle shared by the responder, the bench master driver and the monitor.
interface ei_axi4_slave_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ei_axi4_slave_responder.sv
// AXI4 slave backed by a byte-addressed memory; independent write and read FSMs,
// FIXED/INCR/WRAP bursts, narrow sizes, strobes, SLVERR on burst and range errors.
module ei_axi4_slave_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic aclk,
    input  logic areset,
    ei_axi4_slave_responder_if.slave s_axi
);
    localparam int BUS_BYTES = DATA_WIDTH / 8;
    localparam int LANE_W    = $clog2(BUS_BYTES);
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [7:0] r_mem [MEM_BYTES];

    function automatic logic f_addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] al;
        al = a & ~ADDR_WIDTH'(BUS_BYTES - 1);
        return al >= ADDR_WIDTH'(MEM_BYTES);
    endfunction

    function automatic logic f_burst_err(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        logic err;
        err = (burst == 2'b11) || (size > 3'(LANE_W));
        if (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            err = 1'b1;
        return err;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [7:0] len,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes, span, lower, nxt;
        bytes = ADDR_WIDTH'(1) << size;
        span  = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        lower = a & ~(span - ADDR_WIDTH'(1));
        nxt   = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        if (burst == BURST_FIXED)
            nxt = a;
        else if (burst == BURST_WRAP && nxt == lower + span)
            nxt = lower;
        return nxt;
    endfunction

    // Write path state
    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic [7:0]            r_wcnt, w_wcnt_nxt;
    logic                  r_werr, w_werr_nxt;
    logic                  r_wberr, w_wberr_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt;
    logic [7:0]            r_wlen, w_wlen_nxt;
    logic [2:0]            r_wsize, w_wsize_nxt;
    logic [1:0]            r_wburst, w_wburst_nxt;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wfinal, w_wbeat_err, w_mem_we;
    logic [MEM_AW-1:0]     w_wr_base;

    // Read path state
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic                  r_rlast, w_rlast_nxt;
    logic [7:0]            r_rcnt, w_rcnt_nxt;
    logic                  r_rberr, w_rberr_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt;
    logic [7:0]            r_rlen, w_rlen_nxt;
    logic [2:0]            r_rsize, w_rsize_nxt;
    logic [1:0]            r_rburst, w_rburst_nxt;
    logic                  w_ar_hs, w_r_hs, w_rd_load;
    logic [MEM_AW-1:0]     w_rd_base;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_aw_hs     = s_axi.awvalid && r_awready;
    assign w_w_hs      = s_axi.wvalid && r_wready;
    assign w_b_hs      = r_bvalid && s_axi.bready;
    assign w_wfinal    = (r_wcnt == r_wlen);
    assign w_wbeat_err = (s_axi.wlast != w_wfinal) || f_addr_err(r_waddr);
    assign w_mem_we    = w_w_hs && !r_wberr && !f_addr_err(r_waddr);
    assign w_wr_base   = r_waddr[MEM_AW-1:0] & ~MEM_AW'(BUS_BYTES - 1);
    assign w_ar_hs     = s_axi.arvalid && r_arready;
    assign w_r_hs      = r_rvalid && s_axi.rready;
    assign w_rd_base   = r_raddr[MEM_AW-1:0] & ~MEM_AW'(BUS_BYTES - 1);

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_wcnt_nxt    = r_wcnt;
        w_werr_nxt    = r_werr;
        w_wberr_nxt   = r_wberr;
        w_waddr_nxt   = r_waddr;
        w_wlen_nxt    = r_wlen;
        w_wsize_nxt   = r_wsize;
        w_wburst_nxt  = r_wburst;
        case (r_wstate)
            W_IDLE: begin
                w_awready_nxt = !w_aw_hs;
                if (w_aw_hs) begin
                    w_waddr_nxt  = s_axi.awaddr;
                    w_wlen_nxt   = s_axi.awlen;
                    w_wsize_nxt  = s_axi.awsize;
                    w_wburst_nxt = s_axi.awburst;
                    w_wcnt_nxt   = '0;
                    w_wberr_nxt  = f_burst_err(s_axi.awlen, s_axi.awsize, s_axi.awburst);
                    w_werr_nxt   = w_wberr_nxt;
                    w_wready_nxt = 1'b1;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    w_waddr_nxt = f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                    w_wcnt_nxt  = r_wcnt + 8'd1;
                    w_werr_nxt  = r_werr || w_wbeat_err;
                    if (w_wfinal) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
                        w_wstate_nxt = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_bvalid_nxt  = 1'b0;
                    w_bresp_nxt   = RESP_OKAY;
                    w_awready_nxt = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Bus-aligned word currently addressed by the read path
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < BUS_BYTES; i++)
            w_rd_word[8*i +: 8] = r_mem[w_rd_base + MEM_AW'(i)];
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        w_rlast_nxt   = r_rlast;
        w_rcnt_nxt    = r_rcnt;
        w_rberr_nxt   = r_rberr;
        w_raddr_nxt   = r_raddr;
        w_rlen_nxt    = r_rlen;
        w_rsize_nxt   = r_rsize;
        w_rburst_nxt  = r_rburst;
        w_rd_load     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = !w_ar_hs;
                if (w_ar_hs) begin
                    w_raddr_nxt  = s_axi.araddr;
                    w_rlen_nxt   = s_axi.arlen;
                    w_rsize_nxt  = s_axi.arsize;
                    w_rburst_nxt = s_axi.arburst;
                    w_rcnt_nxt   = '0;
                    w_rberr_nxt  = f_burst_err(s_axi.arlen, s_axi.arsize, s_axi.arburst);
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (!r_rvalid) begin
                    w_rd_load = 1'b1;
                end else if (w_r_hs) begin
                    if (r_rlast) begin
                        w_rvalid_nxt  = 1'b0;
                        w_rlast_nxt   = 1'b0;
                        w_arready_nxt = 1'b1;
                        w_rstate_nxt  = R_IDLE;
                    end else begin
                        w_rd_load = 1'b1;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        // r_raddr always points at the beat to be presented next
        if (w_rd_load) begin
            w_rvalid_nxt = 1'b1;
            w_rlast_nxt  = (r_rcnt == r_rlen);
            w_rcnt_nxt   = r_rcnt + 8'd1;
            w_raddr_nxt  = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
            if (r_rberr || f_addr_err(r_raddr)) begin
                w_rdata_nxt = '0;
                w_rresp_nxt = RESP_SLVERR;
            end else begin
                w_rdata_nxt = w_rd_word;
                w_rresp_nxt = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wberr   <= 1'b0;
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
            r_rcnt    <= '0;
            r_rberr   <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_werr    <= w_werr_nxt;
            r_wberr   <= w_wberr_nxt;
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rberr   <= w_rberr_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        r_waddr  <= w_waddr_nxt;
        r_wlen   <= w_wlen_nxt;
        r_wsize  <= w_wsize_nxt;
        r_wburst <= w_wburst_nxt;
        r_raddr  <= w_raddr_nxt;
        r_rlen   <= w_rlen_nxt;
        r_rsize  <= w_rsize_nxt;
        r_rburst <= w_rburst_nxt;
    end

    // Memory survives reset; reads in the same cycle see the pre-write contents
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BUS_BYTES; i++)
                if (s_axi.wstrb[i])
                    r_mem[w_wr_base + MEM_AW'(i)] <= s_axi.wdata[8*i +: 8];
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rlast   = r_rlast;
endmodule

// File: doc/ei_axi4_slave_responder.md
Name: ei_axi4_slave_responder

Overview:
- AXI4 slave (responder) for the VIP: answers master-driven write (AW/W/B) and read (AR/R) traffic from a local byte-addressed memory.
- Sits on the slave end of the AXI4 bus; the bench master driver and monitor connect to the same signals.
- Supports FIXED/INCR/WRAP bursts, narrow sizes and byte strobes; flags protocol and address errors with SLVERR.
- Write and read paths are independent FSMs and run concurrently.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; one of 32, 64 or 128.
- ADDR_WIDTH, 32: address width in bits.
- MEM_BYTES, 4096: memory size in bytes; a power of 2.

Ports:
- aclk  in  1  clock; all logic on posedge.
- areset  in  1  asynchronous, active-high reset.
- awaddr/awlen/awsize/awburst  in  ADDR_WIDTH/8/3/2  write address channel.
- awvalid  in  1 / awready  out  1  AW handshake.
- wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- wready  out  1  W handshake.
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response channel.
- araddr/arlen/arsize/arburst  in  ADDR_WIDTH/8/3/2  read address channel.
- arvalid  in  1 / arready  out  1  AR handshake.
- rdata  out  DATA_WIDTH / rresp  out  2 / rlast  out  1 / rvalid  out  1 / rready  in  1  read data channel.

Behaviour:
- Reset (async assert): every output is 0 (awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast).
- Reset abandons any burst in progress. Bytes already written stay in memory; memory is never cleared by reset.
- First posedge after reset release: both FSMs go to IDLE; awready=1 and arready=1 appear as registered outputs.
- All outputs are registered.
- Transfers: a transfer occurs when valid&&ready at a posedge. Beats = len+1. Bytes per beat = 1<<size.
- Address sequence:
  - FIXED: address is unchanged for every beat.
  - INCR: next = (addr aligned down to size) + bytes.
  - WRAP: wrap span = bytes*(len+1); lower bound = addr aligned down to span; when next reaches lower+span it returns to lower.
  - Address arithmetic is ADDR_WIDTH bits with no 4KB checking.
- Byte lanes: lane i of the bus maps to (addr aligned down to DATA_WIDTH/8)+i.
- Burst errors, which force SLVERR for the whole burst and suppress all its memory writes:
  - burst=2'b11;
  - WRAP with len not in {1,3,7,15};
  - size > log2(DATA_WIDTH/8).
- Address error: any beat whose aligned bus address is >= MEM_BYTES gets SLVERR. For a write, that beat is dropped; other beats proceed normally.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, capture addr/len/size/burst, clear the beat counter and error flag, deassert awready, assert wready, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the lanes whose wstrb bit is 1, advances the address and increments the counter.
  - wlast=1 on a non-final beat, or wlast=0 on the final beat, sets the error flag. The beat count always comes from awlen.
  - On the final beat: deassert wready, assert bvalid, set bresp=2'b10 if any error occurred, else 2'b00; go to W_RESP.
  - W_RESP: bvalid/bresp are held until bready. The cycle after the B handshake, awready=1 (W_IDLE).
  - W beats arriving before AW are not accepted (wready=0 in W_IDLE).
- Read FSM:
  - R_IDLE: arready=1. AR handshake at edge N: capture fields, arready=0, go to R_DATA.
  - The first beat is registered with rvalid=1 at edge N+1 (one-cycle latency).
  - R_DATA: rdata/rresp/rlast are held stable while rvalid && !rready.
  - On an R handshake of a non-final beat, the next beat is presented at the same edge, so back-to-back beats run with rready held high.
  - rlast=1 only on beat len. After the final handshake: rvalid=0, rlast=0, arready=1 (R_IDLE).
  - Out-of-range and burst-error beats return rdata=0, rresp=2'b10.
- Simultaneous write and read to the same bytes in one cycle: the read returns the pre-write data.

Test Plan:
- AW INCR addr=0x10 len=3 size=2, W 0x11111111..0x44444444 with wstrb=0xF and wlast on beat 3 -> bresp=00. Then AR with the same fields -> rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 with rresp=00 and rlast only on beat 4; first rvalid one cycle after the AR handshake.
- WRAP addr=0x38 len=3 size=2 -> write addresses 0x38, 0x3C, 0x30, 0x34. Readback in the same order matches; bresp=00.
- Narrow/strobe: FIXED addr=0x20 size=0 len=1, wstrb=0x1 then 0x1, data 0xAA then 0xBB -> the byte at 0x20 reads 0xBB; bytes 0x21-0x23 are unchanged.
- Errors:
  - AW addr=0x1000 (MEM_BYTES=4096) len=0 -> bresp=10 and memory unchanged.
  - AR burst=11 -> rresp=10 and rdata=0 on every beat.
  - W with wlast on beat 1 of a len=3 burst -> all 4 beats are accepted and bresp=10.
- Backpressure: bready low for 5 cycles -> bvalid/bresp stable and awready=0 throughout. rready toggled every cycle over len=7 -> 8 beats in order, rdata held while stalled.
- Reset mid-burst: areset pulses after beat 1 of a len=3 write -> all outputs 0 immediately; after release awready=1; beat 0-1 data persists in memory.
